// File: rtl/status_cond_unit.sv
// Architectural {z,c,n,v} status register, ARM condition evaluation for ID,
// and in-flight flag-writer tracking that stalls ID until its flags are final.
module status_cond_unit #(
  parameter bit BYPASS   = 1'b1,
  parameter int MAX_PEND = 3,
  parameter int PEND_W   = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        sr_in_i,
  input  logic              sr_we_i,
  input  logic              issue_s_i,
  input  logic              flush_i,
  input  logic              cond_req_i,
  input  logic [3:0]        cond_i,
  output logic              cond_ok_o,
  output logic              stall_o,
  output logic [3:0]        sr_o,
  output logic [PEND_W-1:0] pend_cnt_o,
  output logic              err_o
);

  localparam logic [PEND_W-1:0] MAX_P = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] ONE   = PEND_W'(1);
  localparam logic [3:0]        COND_AL = 4'b1110;

  logic [3:0]        sr_q, sr_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              err_q, err_d;

  logic       bypass_hit;
  logic [3:0] flags;
  logic       fz, fc, fn, fv;
  logic       cond_pass;
  logic       dep_stall, full_stall, stall;
  logic       inc;

  // Last pending writer committing this cycle can feed its flags straight through.
  assign bypass_hit = BYPASS && sr_we_i && (pend_q == ONE);
  assign flags      = bypass_hit ? sr_in_i : sr_q;
  assign {fz, fc, fn, fv} = flags;

  assign dep_stall  = cond_req_i && (cond_i != COND_AL) &&
                      ((pend_q > ONE) || ((pend_q == ONE) && !bypass_hit));
  assign full_stall = issue_s_i && (pend_q == MAX_P) && !sr_we_i;
  assign stall      = dep_stall || full_stall;
  assign inc        = issue_s_i && !stall;

  always_comb begin
    cond_pass = 1'b0;
    case (cond_i)
      4'b0000: cond_pass = fz;
      4'b0001: cond_pass = !fz;
      4'b0010: cond_pass = fc;
      4'b0011: cond_pass = !fc;
      4'b0100: cond_pass = fn;
      4'b0101: cond_pass = !fn;
      4'b0110: cond_pass = fv;
      4'b0111: cond_pass = !fv;
      4'b1000: cond_pass = fc && !fz;
      4'b1001: cond_pass = !fc || fz;
      4'b1010: cond_pass = (fn == fv);
      4'b1011: cond_pass = (fn != fv);
      4'b1100: cond_pass = !fz && (fn == fv);
      4'b1101: cond_pass = fz || (fn != fv);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    sr_d   = sr_we_i ? sr_in_i : sr_q;
    pend_d = pend_q;
    err_d  = err_q;
    if (flush_i) begin
      pend_d = '0;
    end else if (inc && !sr_we_i) begin
      pend_d = pend_q + ONE;
    end else if (!inc && sr_we_i && (pend_q != '0)) begin
      pend_d = pend_q - ONE;
    end
    // A commit with nothing in flight means the pipeline lost track of a writer.
    if (sr_we_i && (pend_q == '0) && !flush_i) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q   <= 4'b0000;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign cond_ok_o  = cond_req_i && !stall && cond_pass;
  assign stall_o    = stall;
  assign sr_o       = sr_q;
  assign pend_cnt_o = pend_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_status_cond_unit.sv
// Bench for status_cond_unit: two instances (bypass on / off) checked every cycle
// against a flag/count model, plus literal expectations for the directed scenarios.
module tb_status_cond_unit;

  localparam int MAXP = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sr_in;
  logic       sr_we, issue_s, flush, cond_req;
  logic [3:0] cond;

  logic       ok_w    [2];
  logic       stall_w [2];
  logic [3:0] sr_w    [2];
  logic [2:0] pend_w  [2];
  logic       err_w   [2];

  int total = 0;
  int bad   = 0;

  int       m_pend [2];
  bit [3:0] m_sr   [2];
  bit       m_err  [2];

  always #5 clk = ~clk;

  status_cond_unit #(.BYPASS(1'b1), .MAX_PEND(MAXP), .PEND_W(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sr_in_i(sr_in), .sr_we_i(sr_we),
    .issue_s_i(issue_s), .flush_i(flush), .cond_req_i(cond_req), .cond_i(cond),
    .cond_ok_o(ok_w[0]), .stall_o(stall_w[0]), .sr_o(sr_w[0]),
    .pend_cnt_o(pend_w[0]), .err_o(err_w[0])
  );

  status_cond_unit #(.BYPASS(1'b0), .MAX_PEND(MAXP), .PEND_W(3)) dut_nb (
    .clk_i(clk), .rst_ni(rst_n), .sr_in_i(sr_in), .sr_we_i(sr_we),
    .issue_s_i(issue_s), .flush_i(flush), .cond_req_i(cond_req), .cond_i(cond),
    .cond_ok_o(ok_w[1]), .stall_o(stall_w[1]), .sr_o(sr_w[1]),
    .pend_cnt_o(pend_w[1]), .err_o(err_w[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Condition truth: even codes test a predicate, the odd partner is its inverse.
  function automatic bit passes(input bit [3:0] c, input bit [3:0] f);
    bit z, cy, n, v, r;
    {z, cy, n, v} = f;
    case (int'(c) / 2)
      0: r = z;
      1: r = cy;
      2: r = n;
      3: r = v;
      4: r = cy && !z;
      5: r = (n == v);
      6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0]) r = !r;
    if (c == 4'hf) r = 1'b0;
    return r;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int       p;
      bit       byp, dep, full, e_stall, e_ok, inc;
      bit [3:0] f;
      if (!rst_n) begin
        m_pend[i] = 0;
        m_sr[i]   = 4'b0000;
        m_err[i]  = 1'b0;
      end
      p       = m_pend[i];
      byp     = (i == 0) && sr_we && (p == 1);
      f       = byp ? sr_in : m_sr[i];
      dep     = cond_req && (cond != 4'b1110) && (p >= 2 || (p == 1 && !byp));
      full    = issue_s && (p == MAXP) && !sr_we;
      e_stall = dep || full;
      e_ok    = cond_req && !e_stall && passes(cond, f);
      chk($sformatf("m%0d_sr", i), int'(sr_w[i]), int'(m_sr[i]));
      chk($sformatf("m%0d_pend", i), int'(pend_w[i]), p);
      chk($sformatf("m%0d_err", i), int'(err_w[i]), int'(m_err[i]));
      if (!(flush && cond_req)) begin
        chk($sformatf("m%0d_stall", i), int'(stall_w[i]), int'(e_stall));
        chk($sformatf("m%0d_cond_ok", i), int'(ok_w[i]), int'(e_ok));
      end
      if (rst_n) begin
        if (sr_we) m_sr[i] = sr_in;
        if (sr_we && p == 0 && !flush) m_err[i] = 1'b1;
        inc = issue_s && !e_stall;
        if (flush) m_pend[i] = 0;
        else if (inc && !sr_we) m_pend[i] = p + 1;
        else if (!inc && sr_we && p > 0) m_pend[i] = p - 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [3:0] fl [8];
    fl = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0110, 4'b1011, 4'b0101};
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_sr[i] = 4'b0000; m_err[i] = 1'b0;
    end
    rst_n = 1'b0; sr_in = 4'b0; sr_we = 1'b0; issue_s = 1'b0; flush = 1'b0;
    cond_req = 1'b1; cond = 4'b0000;

    // Reset state: EQ fails, NE passes on cleared flags
    #2;
    chk("t1_eq_stall", int'(stall_w[0]), 0);
    chk("t1_eq_ok", int'(ok_w[0]), 0);
    chk("t1_rst_sr", int'(sr_w[0]), 0);
    cond = 4'b0001;
    #1;
    chk("t1_ne_ok", int'(ok_w[0]), 1);
    #9;
    rst_n = 1'b1; cond_req = 1'b0;

    // Orphan commit: sets err, loads Z
    step(); sr_we = 1'b1; sr_in = 4'b1000;
    step(); sr_we = 1'b0; cond_req = 1'b1; cond = 4'b0000;
    @(negedge clk);
    chk("t2_sr", int'(sr_w[0]), 8);
    chk("t2_err", int'(err_w[0]), 1);
    chk("t2_eq_ok", int'(ok_w[0]), 1);
    step(); cond = 4'b1101;
    @(negedge clk);
    chk("t2_le_ok", int'(ok_w[0]), 1);

    // Bypass of the single pending writer
    step(); cond_req = 1'b0; issue_s = 1'b1;
    step(); issue_s = 1'b0; cond_req = 1'b1; cond = 4'b1010; sr_we = 1'b1; sr_in = 4'b0011;
    @(negedge clk);
    chk("t3_pend", int'(pend_w[0]), 1);
    chk("t3_byp_stall", int'(stall_w[0]), 0);
    chk("t3_byp_ok", int'(ok_w[0]), 1);
    chk("t3_nb_stall", int'(stall_w[1]), 1);
    chk("t3_nb_ok", int'(ok_w[1]), 0);
    step(); sr_we = 1'b0;
    @(negedge clk);
    chk("t3_nb_stall2", int'(stall_w[1]), 0);
    chk("t3_nb_ok2", int'(ok_w[1]), 1);
    chk("t3_nb_sr", int'(sr_w[1]), 3);
    chk("t3_nb_pend", int'(pend_w[1]), 0);

    // Fill to MAX_PEND, full stall, then slot freed by a commit
    step(); cond_req = 1'b0; issue_s = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_fill_pend", int'(pend_w[0]), k);
      chk("t4_fill_stall", int'(stall_w[0]), 0);
      step();
    end
    @(negedge clk);
    chk("t4_full_pend", int'(pend_w[0]), 3);
    chk("t4_full_stall", int'(stall_w[0]), 1);
    step(); sr_we = 1'b1; sr_in = 4'b0101;
    @(negedge clk);
    chk("t4_free_pend", int'(pend_w[0]), 3);
    chk("t4_free_stall", int'(stall_w[0]), 0);
    step(); issue_s = 1'b0;
    @(negedge clk);
    chk("t4_incdec_pend", int'(pend_w[0]), 3);
    step(); sr_we = 1'b0; cond_req = 1'b1; cond = 4'b0000;
    @(negedge clk);
    chk("t5_pend", int'(pend_w[0]), 2);
    chk("t5_dep_stall", int'(stall_w[0]), 1);
    chk("t5_dep_ok", int'(ok_w[0]), 0);
    step(); cond = 4'b1110;
    @(negedge clk);
    chk("t5_al_stall", int'(stall_w[0]), 0);
    chk("t5_al_ok", int'(ok_w[0]), 1);
    step(); cond = 4'b1111;
    @(negedge clk);
    chk("t5_nv_ok", int'(ok_w[0]), 0);

    // Flush with a concurrent commit, then async reset mid-stream
    step(); cond_req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_err", int'(err_w[0]), 0);
    step(); rst_n = 1'b1; issue_s = 1'b1;
    step();
    step(); issue_s = 1'b0; flush = 1'b1; sr_we = 1'b1; sr_in = 4'b0100;
    @(negedge clk);
    chk("t6_pre_pend", int'(pend_w[0]), 2);
    step(); flush = 1'b0; sr_we = 1'b0; issue_s = 1'b1;
    @(negedge clk);
    chk("t6_fl_pend", int'(pend_w[0]), 0);
    chk("t6_fl_sr", int'(sr_w[0]), 4);
    chk("t6_fl_err", int'(err_w[0]), 0);
    @(posedge clk);
    #1 issue_s = 1'b0;
    chk("t6_mid_pend", int'(pend_w[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_sr", int'(sr_w[0]), 0);
    chk("t6_async_pend", int'(pend_w[0]), 0);
    step(); rst_n = 1'b1;

    // Every condition against a spread of registered flags
    for (int s = 0; s < 8; s++) begin
      step(); cond_req = 1'b0; sr_we = 1'b1; sr_in = fl[s];
      step(); sr_we = 1'b0; cond_req = 1'b1;
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        step();
      end
    end

    // Every condition through the bypass path
    for (int s = 4; s < 8; s++) begin
      for (int c = 0; c < 16; c++) begin
        cond_req = 1'b0; sr_we = 1'b0; issue_s = 1'b1;
        step(); issue_s = 1'b0; cond_req = 1'b1; cond = 4'(c); sr_we = 1'b1; sr_in = fl[s];
        step();
      end
    end
    cond_req = 1'b0; sr_we = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
